// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   This block lets two requesters share the single-ported 64K x 8 CPU memory:
//   the 6502 core (port C) and a DMA/peripheral engine (port D). At most one
//   access is granted per cycle, and the granted port drives the memory's
//   mw/addr/data_in. Read data comes back to the winning requester one cycle
//   after its grant, which matches the memory's registered read.
//
//   The CPU has fixed priority. An anti-starvation counter counts the
//   consecutive cycles in which DMA asked and was denied. Once that count
//   reaches MAX_WAIT, DMA wins the next contested cycle.
//
// Parameters:
//   MAX_WAIT : denied DMA request cycles before DMA is forced through (1..15)
//   WAIT_W   : width of the wait counter; 2**WAIT_W must exceed MAX_WAIT
//
// Ports:
//   clk, reset_n                     : system clock, async active-low reset
//   cpu_req/mw/addr/wdata            : CPU request (held until cpu_gnt)
//   cpu_gnt                          : combinational grant, this cycle
//   cpu_rdata, cpu_rvalid            : read return, cycle after a READ grant
//   dma_*                            : same set for the DMA port
//   mem_mw, mem_addr, mem_wdata      : drive to the memory
//   mem_rdata                        : registered data_out from the memory
// -----------------------------------------------------------------------------

package mem_arbiter_pkg;
  typedef enum logic {
    MW_READ  = 1'b0,
    MW_WRITE = 1'b1
  } mw_t;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic  clk,
  input  logic  reset_n,

  input  logic  cpu_req,
  input  mw_t   cpu_mw,
  input  addr_t cpu_addr,
  input  data_t cpu_wdata,
  output logic  cpu_gnt,
  output data_t cpu_rdata,
  output logic  cpu_rvalid,

  input  logic  dma_req,
  input  mw_t   dma_mw,
  input  addr_t dma_addr,
  input  data_t dma_wdata,
  output logic  dma_gnt,
  output data_t dma_rdata,
  output logic  dma_rvalid,

  output mw_t   mem_mw,
  output addr_t mem_addr,
  output data_t mem_wdata,
  input  data_t mem_rdata
);

  // Records which port, if any, owns the read data arriving next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  owner_t            rd_owner_reg;
  owner_t            rd_owner_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              cpu_rvalid_reg;
  logic              dma_rvalid_reg;

  logic              starve;
  logic              cpu_win;
  logic              dma_win;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // The starve flag overrides CPU priority only when both ports are
  // requesting. A lone requester always wins. Gating the grants with reset_n
  // keeps the memory from being written while reset is asserted, even if a
  // requester is still holding its request.
  assign starve  = (wait_cnt_reg >= WAIT_LIMIT);

  assign cpu_win = reset_n & cpu_req & ~(dma_req & starve);
  assign dma_win = reset_n & dma_req & (~cpu_req | starve);

  assign cpu_gnt = cpu_win;
  assign dma_gnt = dma_win;

  // ---------------------------------------------------------------------------
  // Memory drive
  // ---------------------------------------------------------------------------
  // When nothing is granted, the memory sees a harmless READ of address 0,
  // so a write can never happen without a grant.
  always_comb begin
    mem_mw    = MW_READ;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_win) begin
      mem_mw    = cpu_mw;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_win) begin
      mem_mw    = dma_mw;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_owner_next = OWN_NONE;
    if (cpu_win && (cpu_mw == MW_READ)) begin
      rd_owner_next = OWN_CPU;
    end else if (dma_win && (dma_mw == MW_READ)) begin
      rd_owner_next = OWN_DMA;
    end
  end

  // The counter tracks consecutive denied DMA cycles. A grant, or DMA
  // dropping its request, ends the streak. Holding at the limit keeps the
  // starve flag asserted until DMA actually gets through.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!dma_req || dma_win) begin
      wait_cnt_next = '0;
    end else if (!starve) begin
      wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered read-return flags
  // ---------------------------------------------------------------------------
  // The rvalid flags are registered next to the owner tag, so an asynchronous
  // reset clears a pending return immediately. It is not delivered after
  // reset releases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_owner_reg   <= OWN_NONE;
      wait_cnt_reg   <= '0;
      cpu_rvalid_reg <= 1'b0;
      dma_rvalid_reg <= 1'b0;
    end else begin
      rd_owner_reg   <= rd_owner_next;
      wait_cnt_reg   <= wait_cnt_next;
      cpu_rvalid_reg <= (rd_owner_next == OWN_CPU);
      dma_rvalid_reg <= (rd_owner_next == OWN_DMA);
    end
  end

  // ---------------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------------
  // The memory already registers its output, so the data passes straight
  // through to both ports. Consumers qualify it with their rvalid.
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign cpu_rvalid = cpu_rvalid_reg;
  assign dma_rvalid = dma_rvalid_reg;

endmodule
